// File: rtl/hall_sensor_emulator.sv
// Hall sensor pattern generator emulating a spinning BLDC motor for loopback
// self-test: timed or single-step sector advance, fault injection, rev counter.
module hall_sensor_emulator #(
    parameter int PERIOD_WIDTH = 16,
    parameter int REV_WIDTH    = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    dir,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    single_step,
    input  logic [1:0]              fault_mode,
    output logic [2:0]              hall,
    output logic [2:0]              sector,
    output logic                    step,
    output logic [REV_WIDTH-1:0]    rev_count
);

    localparam logic [1:0] FM_NORMAL = 2'b00;
    localparam logic [1:0] FM_ZERO   = 2'b01;
    localparam logic [1:0] FM_ONES   = 2'b10;
    localparam logic [1:0] FM_FREEZE = 2'b11;

    // Forward order; exactly one bit flips between neighbouring sectors.
    function automatic logic [2:0] hall_map(input logic [2:0] s);
        case (s)
            3'd0:    hall_map = 3'b101;
            3'd1:    hall_map = 3'b100;
            3'd2:    hall_map = 3'b110;
            3'd3:    hall_map = 3'b010;
            3'd4:    hall_map = 3'b011;
            3'd5:    hall_map = 3'b001;
            default: hall_map = 3'b101;
        endcase
    endfunction

    logic [PERIOD_WIDTH-1:0] timer, timer_nxt, period_m1;
    logic [2:0]              sector_nxt, hall_nxt;
    logic [REV_WIDTH-1:0]    rev_nxt;
    logic                    freeze, run, advance;

    assign freeze    = (fault_mode == FM_FREEZE);
    assign run       = enable && (period != '0) && !freeze;
    assign period_m1 = period - PERIOD_WIDTH'(1);

    always_comb begin
        timer_nxt  = '0;
        advance    = 1'b0;
        sector_nxt = sector;
        rev_nxt    = rev_count;
        hall_nxt   = hall;

        // >= so that shrinking the period below the running count fires at once
        if (run) begin
            if (timer >= period_m1) advance = 1'b1;
            else                    timer_nxt = timer + PERIOD_WIDTH'(1);
        end
        if (!enable && single_step && !freeze) advance = 1'b1;

        if (advance) begin
            if (!dir) begin
                if (sector == 3'd5) begin
                    sector_nxt = 3'd0;
                    rev_nxt    = rev_count + REV_WIDTH'(1);
                end else begin
                    sector_nxt = sector + 3'd1;
                end
            end else begin
                if (sector == 3'd0) begin
                    sector_nxt = 3'd5;
                    rev_nxt    = rev_count - REV_WIDTH'(1);
                end else begin
                    sector_nxt = sector - 3'd1;
                end
            end
        end

        case (fault_mode)
            FM_NORMAL: hall_nxt = hall_map(sector_nxt);
            FM_ZERO:   hall_nxt = 3'b000;
            FM_ONES:   hall_nxt = 3'b111;
            default:   hall_nxt = hall;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer     <= '0;
            sector    <= 3'd0;
            hall      <= 3'b101;
            step      <= 1'b0;
            rev_count <= '0;
        end else begin
            timer     <= timer_nxt;
            sector    <= sector_nxt;
            hall      <= hall_nxt;
            step      <= advance;
            rev_count <= rev_nxt;
        end
    end

endmodule

// File: tb/tb_hall_sensor_emulator.sv
// Directed + randomized bench for hall_sensor_emulator against a cycle-level
// arithmetic reference model (sector modulo 6, integer revolution count).
module tb_hall_sensor_emulator;

    localparam int PW = 16;
    localparam int RW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          dir;
    logic [PW-1:0] period;
    logic          single_step;
    logic [1:0]    fault_mode;
    logic [2:0]    hall;
    logic [2:0]    sector;
    logic          step;
    logic [RW-1:0] rev_count;

    hall_sensor_emulator #(.PERIOD_WIDTH(PW), .REV_WIDTH(RW)) dut (
        .clock(clock), .reset(reset), .enable(enable), .dir(dir),
        .period(period), .single_step(single_step), .fault_mode(fault_mode),
        .hall(hall), .sector(sector), .step(step), .rev_count(rev_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int steps_seen;

    logic [2:0] hmap [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    int         m_timer, m_sector, m_rev;
    logic [2:0] m_hall;
    bit         m_step;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_timer = 0; m_sector = 0; m_rev = 0; m_hall = 3'b101; m_step = 0;
    endtask

    // Behaviour from the rules: count cycles toward the period, move one
    // sector (mod 6) per advance, count whole electrical revolutions.
    task automatic model_edge();
        bit frz, run, adv;
        frz = (fault_mode == 2'd3);
        run = enable && (period != 0) && !frz;
        adv = 0;
        if (run) begin
            if (m_timer + 1 >= int'(period)) begin m_timer = 0; adv = 1; end
            else m_timer++;
        end else m_timer = 0;
        if (!enable && single_step && !frz) adv = 1;
        if (adv) begin
            if (!dir) begin
                if (m_sector == 5) m_rev++;
                m_sector = (m_sector + 1) % 6;
            end else begin
                if (m_sector == 0) m_rev--;
                m_sector = (m_sector + 5) % 6;
            end
        end
        m_step = adv;
        case (fault_mode)
            2'd0: m_hall = hmap[m_sector];
            2'd1: m_hall = 3'b000;
            2'd2: m_hall = 3'b111;
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        logic [RW-1:0] rexp;
        rexp = RW'(m_rev);
        check({tag, ".hall"},   32'(hall),      32'(m_hall));
        check({tag, ".sector"}, 32'(sector),    32'(m_sector));
        check({tag, ".step"},   32'(step),      32'(m_step));
        check({tag, ".rev"},    32'(rev_count), 32'(rexp));
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        if (step) steps_seen++;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; dir = 1'b0; period = '0;
        single_step = 1'b0; fault_mode = 2'd0;
        model_reset();
        #12;
        check_all("reset");

        // forward, period 4
        enable = 1'b1; period = 16'd4;
        @(negedge clock); reset = 1'b0;
        steps_seen = 0;
        repeat (24) tick("fwd");
        check("fwd_rev1", 32'(rev_count), 32'd1);
        check("fwd_nsteps", 32'(steps_seen), 32'd6);
        check("fwd_hall", 32'(hall), 32'(3'b101));

        // reverse, period 4 from fresh reset
        reset = 1'b1; #1; model_reset(); dir = 1'b1;
        @(negedge clock); reset = 1'b0;
        repeat (4) tick("rev");
        check("rev_first", 32'(sector), 32'd5);
        check("rev_first_hall", 32'(hall), 32'(3'b001));
        repeat (20) tick("rev");
        check("rev_m1", 32'(rev_count), 32'(16'hFFFF));

        // period shrink mid-count
        dir = 1'b0; period = 16'd10;
        for (int i = 0; i < 40 && m_timer != 7; i++) tick("p10");
        check("p10_timer7", 32'(m_timer), 32'd7);
        period = 16'd3;
        tick("shrink");
        check("shrink_step", 32'(step), 32'd1);
        repeat (7) tick("p3");

        // single step with enable low
        enable = 1'b0; period = 16'd2;
        reset = 1'b1; #1; model_reset();
        @(negedge clock); reset = 1'b0;
        steps_seen = 0;
        for (int k = 0; k < 3; k++) begin
            single_step = 1'b1; tick("ss");
            single_step = 1'b0; repeat (4) tick("ss_gap");
        end
        check("ss_sector", 32'(sector), 32'd3);
        check("ss_hall", 32'(hall), 32'(3'b010));
        check("ss_nsteps", 32'(steps_seen), 32'd3);

        // single step ignored while enabled (period 0 => stalled)
        enable = 1'b1; period = 16'd0; single_step = 1'b1;
        repeat (3) tick("ss_ign");
        single_step = 1'b0;

        // fault modes at period 2
        period = 16'd2;
        repeat (3) tick("pre_fault");
        fault_mode = 2'd1; repeat (6) tick("f000");
        check("f000_hall", 32'(hall), 32'd0);
        fault_mode = 2'd0; tick("f_back");
        check("f_back_map", 32'(hall), 32'(hmap[m_sector]));
        fault_mode = 2'd2; repeat (3) tick("f111");
        check("f111_hall", 32'(hall), 32'(3'b111));

        // freeze then async reset mid-run
        fault_mode = 2'd0; repeat (3) tick("pre_frz");
        fault_mode = 2'd3; steps_seen = 0;
        repeat (8) tick("freeze");
        check("freeze_nsteps", 32'(steps_seen), 32'd0);
        fault_mode = 2'd0; repeat (5) tick("post_frz");
        #2; reset = 1'b1; #1;
        model_reset();
        check_all("async_rst");
        #2; reset = 1'b0;
        repeat (4) tick("post_rst");

        // randomized operation
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 15) == 0) enable = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 19) == 0) dir = 1'($urandom);
            if ($urandom_range(0, 24) == 0) period = PW'($urandom_range(0, 6));
            if ($urandom_range(0, 29) == 0) fault_mode = 2'($urandom);
            single_step = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1; #1; model_reset(); check_all("rnd_rst"); #1; reset = 1'b0;
            end
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hall_sensor_emulator.md
Name: hall_sensor_emulator

Overview:
- Generates a 3-bit hall sensor pattern from a commanded step rate and direction, emulating a spinning BLDC motor.
- Drives the hall inputs of the commutation decoder in FPGA loopback self-test and bench bring-up, with no motor attached.
- Supports fault injection (000/111 patterns and stall) and single-stepping.
- Reports the electrical sector and a signed electrical-revolution count.

Parameters:
- PERIOD_WIDTH, 16, width of the period input and of the internal step timer.
- REV_WIDTH, 16, width of the signed electrical-revolution counter.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  free-running stepping enable
- dir  input  1  0 = forward (sector increments), 1 = reverse (sector decrements)
- period  input  PERIOD_WIDTH  clock cycles per hall step; 0 = stalled
- single_step  input  1  one-cycle request to advance one sector; honoured only when enable=0
- fault_mode  input  2  00 normal, 01 force 000, 10 force 111, 11 freeze
- hall  output  3  emulated hall pattern, registered; bit 2 = hall 1
- sector  output  3  current electrical sector, 0..5
- step  output  1  one-cycle pulse in the cycle hall/sector take a new value
- rev_count  output  REV_WIDTH  signed electrical revolutions, two's complement

Behaviour:
- Reset (async, active-high) values:
  - sector=0, hall=3'b101, step=0, rev_count=0, timer=0.
- Sector-to-hall map (forward order; exactly one bit changes per step):
  - 0:101, 1:100, 2:110, 3:010, 4:011, 5:001.
- Timer, when enable=1 and period!=0 and fault_mode!=11:
  - If timer >= period-1: timer<=0 and an advance occurs. The >= comparison handles period being reduced below the current timer value.
  - Otherwise timer<=timer+1.
  - period=1 gives an advance every cycle.
- When enable=0, or period=0, or fault_mode=11: timer<=0 and no timed advance occurs.
- Single step: single_step=1 with enable=0 and fault_mode!=11 causes one advance on the next clock edge. single_step is ignored when enable=1.
- Advance:
  - dir is sampled in the advance cycle.
  - Forward: sector wraps 5->0. Reverse: sector wraps 0->5.
  - step=1 for exactly that cycle; otherwise step=0.
- Revolution counter:
  - Forward wrap 5->0: rev_count+1.
  - Reverse wrap 0->5: rev_count-1.
  - Wraps modulo 2^REV_WIDTH with no saturation.
- Output latency: hall, sector and step update on the same clock edge (registered). No combinational path from any input to hall.
- Fault modes:
  - 01: hall<=000 while active.
  - 10: hall<=111 while active.
  - In 01/10, sector, timer, step and rev_count keep running normally. When fault_mode returns to 00, hall shows map(current sector) on the next edge.
  - 11: freeze. hall, sector and rev_count hold; timer is cleared.
- dir changes between advances take effect at the next advance. The timer is not reset by a dir change.
- A period change mid-count does not reset the timer.
- Reset asserted mid-operation forces all reset values immediately (asynchronous). Operation resumes from sector 0 on the first clock after release.

Test Plan:
- Reset release, enable=1, dir=0, period=4, fault_mode=00 -> hall steps every 4 cycles through 100,110,010,011,001,101; step pulses 1 cycle each; rev_count=1 after 6 steps (24 cycles).
- Same as above but dir=1 -> hall sequence 001,011,010,110,100,101; rev_count reaches -1 (all ones) after 6 steps; sector goes 0->5 on the first step.
- period=10, then change period to 3 when timer=7 -> advance on the very next cycle; subsequent advances every 3 cycles.
- enable=0, pulse single_step 3 times spaced 5 cycles apart -> sector 0->1->2->3, hall=010, exactly 3 step pulses; period has no effect.
- Running at period=2: fault_mode=01 for 6 cycles -> hall=000 throughout while sector advances 3; then fault_mode=00 -> hall=map(sector) next edge; fault_mode=10 -> hall=111.
- fault_mode=11 mid-run -> hall/sector/rev_count hold and no step pulses. Assert reset mid-run -> hall=101, sector=0, rev_count=0 immediately without a clock edge.
